// File: rtl/mem_access_pkg.sv
// Shared encodings and the access legality check for the data-memory initiator.
package mem_access_pkg;

  localparam int NUM_LANES = 4;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Latched request. Only the lane bits of the address are kept; the word
  // index lives in the memAddress register.
  typedef struct packed {
    logic [1:0]  lane;
    logic        write;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] wdata;
  } req_t;

  // Misalignment, reserved size, or a word index past the end of memory.
  function automatic logic accessErr(input logic [31:0] addr,
                                     input logic [1:0]  size,
                                     input int unsigned memWords);
    logic alignErr;
    case (size)
      SZ_BYTE: alignErr = 1'b0;
      SZ_HALF: alignErr = addr[0];
      SZ_WORD: alignErr = |addr[1:0];
      default: alignErr = 1'b1;
    endcase
    return alignErr | ({2'b00, addr[31:2]} >= 32'(memWords));
  endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Little-endian lane steering: load extraction with sign/zero extension and
// sub-word merge of store data into a fetched word.
module byte_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] wdata,
  output logic [31:0] loadData,
  output logic [31:0] mergedWord
);

  logic [NUM_LANES-1:0][7:0] wordB;
  logic [NUM_LANES-1:0][7:0] repB;
  logic [NUM_LANES-1:0][7:0] mergedB;
  logic [NUM_LANES-1:0]      laneEn;
  logic [7:0]                selByte;
  logic [15:0]               selHalf;

  assign wordB   = word;
  assign selByte = wordB[lane];
  assign selHalf = lane[1] ? word[31:16] : word[15:0];

  always_comb begin
    loadData = word;
    case (size)
      SZ_BYTE: loadData = {{24{sgn & selByte[7]}}, selByte};
      SZ_HALF: loadData = {{16{sgn & selHalf[15]}}, selHalf};
      default: loadData = word;
    endcase
  end

  // Replicate store data across lanes so each lane just picks its own slice.
  always_comb begin
    repB = wdata;
    case (size)
      SZ_BYTE: repB = {NUM_LANES{wdata[7:0]}};
      SZ_HALF: repB = {(NUM_LANES/2){wdata[15:0]}};
      default: repB = wdata;
    endcase
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : gLane
    localparam logic [1:0] LK = 2'(k);
    assign laneEn[k]  = (size == SZ_WORD)
                      | ((size == SZ_HALF) & (lane[1] == LK[1]))
                      | ((size == SZ_BYTE) & (lane == LK));
    assign mergedB[k] = laneEn[k] ? repB[k] : wordB[k];
  end

  assign mergedWord = mergedB;

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-only data memory; sub-word stores are
// performed as read-modify-write through IDLE/READ/WRITE/RESP.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int MEM_WORDS = 8,
  parameter int SIZE_W    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic [31:0]       reqAddr,
  input  logic              reqWrite,
  input  logic [SIZE_W-1:0] reqSize,
  input  logic              reqSigned,
  input  logic [31:0]       reqWData,
  output logic              respValid,
  output logic [31:0]       respRData,
  output logic              respErr,
  output logic [31:0]       memAddress,
  output logic [31:0]       memWriteData,
  output logic              memWrite,
  output logic              memRead,
  input  logic [31:0]       memReadData
);

  state_t      state;
  req_t        req;
  logic [1:0]  inSize;
  logic        inErr;
  logic [31:0] loadData;
  logic [31:0] mergedWord;

  assign inSize   = reqSize[1:0];
  assign inErr    = accessErr(reqAddr, inSize, MEM_WORDS);
  assign reqReady = (state == IDLE) & ~reset;

  byte_lane_align uAlign (
    .word       (memReadData),
    .lane       (req.lane),
    .size       (req.size),
    .sgn        (req.sgn),
    .wdata      (req.wdata),
    .loadData   (loadData),
    .mergedWord (mergedWord)
  );

  // Strobes and respValid are set on the edge entering their state and
  // cleared by default, so each is a single clean registered cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      req          <= '0;
      respValid    <= 1'b0;
      respRData    <= '0;
      respErr      <= 1'b0;
      memAddress   <= '0;
      memWriteData <= '0;
      memWrite     <= 1'b0;
      memRead      <= 1'b0;
    end else begin
      respValid <= 1'b0;
      memRead   <= 1'b0;
      memWrite  <= 1'b0;
      case (state)
        IDLE: begin
          if (reqValid) begin
            req       <= '{lane: reqAddr[1:0], write: reqWrite, size: inSize,
                           sgn: reqSigned, wdata: reqWData};
            respRData <= '0;
            respErr   <= 1'b0;
            if (inErr) begin
              state     <= RESP;
              respValid <= 1'b1;
              respErr   <= 1'b1;
            end else begin
              memAddress <= {2'b00, reqAddr[31:2]};
              if (reqWrite && inSize == SZ_WORD) begin
                state        <= WRITE;
                memWrite     <= 1'b1;
                memWriteData <= reqWData;
              end else begin
                state   <= READ;
                memRead <= 1'b1;
              end
            end
          end
        end
        READ: begin
          if (req.write) begin
            state        <= WRITE;
            memWrite     <= 1'b1;
            memWriteData <= mergedWord;
          end else begin
            state     <= RESP;
            respValid <= 1'b1;
            respRData <= loadData;
          end
        end
        WRITE: begin
          state     <= RESP;
          respValid <= 1'b1;
        end
        RESP: begin
          state     <= IDLE;
          respRData <= '0;
          respErr   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, hand-written corner
// sequences, and random traffic against an arithmetic memory model.
module tb_mem_access_unit;

  localparam int MW = 8;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] wd;
    logic        expErr;
    logic [31:0] expRData;
    int          expLat;
    int          expRd;
    int          expWr;
    logic [31:0] expWData;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic [31:0] reqAddr = '0;
  logic        reqWrite = 1'b0;
  logic [1:0]  reqSize = '0;
  logic        reqSigned = 1'b0;
  logic [31:0] reqWData = '0;
  logic        respValid;
  logic [31:0] respRData;
  logic        respErr;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic        memWrite;
  logic        memRead;
  logic [31:0] memReadData;

  logic [31:0] mem    [MW];
  logic [31:0] refMem [MW];
  logic        initMem = 1'b1;
  int          nCmp = 0;
  int          nBad = 0;
  vec_t        tbl [21];

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_WORDS(MW), .SIZE_W(2)) dut (
    .clk(clk), .reset(reset),
    .reqValid(reqValid), .reqReady(reqReady), .reqAddr(reqAddr),
    .reqWrite(reqWrite), .reqSize(reqSize), .reqSigned(reqSigned),
    .reqWData(reqWData),
    .respValid(respValid), .respRData(respRData), .respErr(respErr),
    .memAddress(memAddress), .memWriteData(memWriteData),
    .memWrite(memWrite), .memRead(memRead), .memReadData(memReadData)
  );

  // Attached memory: combinational read, write committed on the negedge.
  assign memReadData = (memAddress < MW) ? mem[memAddress[2:0]] : 32'hDEADBEEF;
  always @(negedge clk) begin
    if (initMem) begin
      for (int i = 0; i < MW; i++) mem[i] <= 32'(i);
    end else if (memWrite && memAddress < MW) begin
      mem[memAddress[2:0]] <= memWriteData;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic w, input logic [1:0] s,
                              input logic g, input logic [31:0] d, input logic e,
                              input logic [31:0] r, input int l, input int rc,
                              input int wc, input logic [31:0] wdExp);
    vec_t v;
    v.addr = a; v.wr = w; v.sz = s; v.sg = g; v.wd = d;
    v.expErr = e; v.expRData = r; v.expLat = l; v.expRd = rc; v.expWr = wc;
    v.expWData = wdExp;
    return v;
  endfunction

  // Reference behaviour from the access rules: masks and shifts over a word array.
  task automatic model(inout vec_t v);
    int unsigned a, w, sh;
    logic [31:0] mask, old, val;
    a  = v.addr;
    w  = a / 4;
    sh = 8 * (a % 4);
    mask = (v.sz == 0) ? 32'hFF : (v.sz == 1) ? 32'hFFFF : 32'hFFFF_FFFF;
    v.expErr = (v.sz == 3) || (v.sz == 1 && a % 2 != 0) || (v.sz == 2 && a % 4 != 0) || (w >= MW);
    v.expRData = '0; v.expWData = '0; v.expRd = 0; v.expWr = 0;
    if (v.expErr) begin
      v.expLat = 1;
    end else begin
      old = refMem[w];
      if (!v.wr) begin
        val = (old >> sh) & mask;
        if (v.sg && v.sz != 2 && (val & ((mask >> 1) + 1)) != 0) val = val | ~mask;
        v.expRData = val;
        v.expLat = 2;
        v.expRd = 1;
      end else begin
        v.expWData = (old & ~(mask << sh)) | ((v.wd & mask) << sh);
        refMem[w] = v.expWData;
        v.expWr = 1;
        v.expRd = (v.sz == 2) ? 0 : 1;
        v.expLat = 2 + v.expRd;
      end
    end
  endtask

  // Issue one request from a negedge and watch it to completion.
  task automatic doReq(input vec_t v, input string tag);
    int lat, rdCnt, wrCnt, t;
    logic [31:0] rd, wdSeen, adSeen;
    logic err, done;
    t = 0;
    while (!reqReady && t < 20) begin @(negedge clk); t++; end
    reqAddr = v.addr; reqWrite = v.wr; reqSize = v.sz; reqSigned = v.sg; reqWData = v.wd;
    reqValid = 1'b1;
    done = 1'b0; lat = 0; rdCnt = 0; wrCnt = 0; rd = '0; err = 1'b0; wdSeen = '0; adSeen = '0;
    for (int c = 1; c <= 8 && !done; c++) begin
      @(negedge clk);
      reqValid = 1'b0;
      if (memRead)  begin rdCnt++; adSeen = memAddress; end
      if (memWrite) begin wrCnt++; wdSeen = memWriteData; end
      if (respValid) begin done = 1'b1; lat = c; rd = respRData; err = respErr; end
    end
    if (!done) begin
      nCmp++; nBad++;
      $display("FAIL %s timeout: got no respValid expected one", tag);
    end else begin
      chk({tag, " latency"}, 32'(lat), 32'(v.expLat));
      chk({tag, " respErr"}, {31'b0, err}, {31'b0, v.expErr});
      chk({tag, " respRData"}, rd, v.expRData);
      chk({tag, " memRead cycles"}, 32'(rdCnt), 32'(v.expRd));
      chk({tag, " memWrite cycles"}, 32'(wrCnt), 32'(v.expWr));
      if (v.expWr > 0) chk({tag, " memWriteData"}, wdSeen, v.expWData);
      if (v.expRd > 0) chk({tag, " memAddress"}, adSeen, v.addr >> 2);
      @(negedge clk);
      chk({tag, " respValid width"}, {31'b0, respValid}, 32'd0);
    end
  endtask

  initial begin
    vec_t v;
    int idx, nResp, quiet;
    int acc [3];
    logic [31:0] got [3];
    logic chg;

    for (int i = 0; i < MW; i++) refMem[i] = 32'(i);

    // Reset state
    repeat (3) @(negedge clk);
    chk("reqReady during reset", {31'b0, reqReady}, 32'd0);
    reset = 1'b0; initMem = 1'b0;
    @(negedge clk);
    chk("reset reqReady", {31'b0, reqReady}, 32'd1);
    chk("reset respValid", {31'b0, respValid}, 32'd0);
    chk("reset respErr", {31'b0, respErr}, 32'd0);
    chk("reset respRData", respRData, 32'd0);
    chk("reset memWrite", {31'b0, memWrite}, 32'd0);
    chk("reset memRead", {31'b0, memRead}, 32'd0);
    chk("reset memAddress", memAddress, 32'd0);
    chk("reset memWriteData", memWriteData, 32'd0);

    // Directed vectors (memory starts with word i = i)
    tbl[0]  = mk(32'h08, 0, 2, 0, 32'h0,        0, 32'h0000_0002, 2, 1, 0, 32'h0);
    tbl[1]  = mk(32'h04, 1, 2, 0, 32'h12345680, 0, 32'h0,         2, 0, 1, 32'h12345680);
    tbl[2]  = mk(32'h04, 0, 0, 1, 32'h0,        0, 32'hFFFF_FF80, 2, 1, 0, 32'h0);
    tbl[3]  = mk(32'h04, 0, 0, 0, 32'h0,        0, 32'h0000_0080, 2, 1, 0, 32'h0);
    tbl[4]  = mk(32'h06, 0, 1, 1, 32'h0,        0, 32'h0000_1234, 2, 1, 0, 32'h0);
    tbl[5]  = mk(32'h04, 0, 1, 0, 32'h0,        0, 32'h0000_5680, 2, 1, 0, 32'h0);
    tbl[6]  = mk(32'h05, 1, 0, 0, 32'hAB,       0, 32'h0,         3, 1, 1, 32'h1234AB80);
    tbl[7]  = mk(32'h04, 0, 2, 0, 32'h0,        0, 32'h1234_AB80, 2, 1, 0, 32'h0);
    tbl[8]  = mk(32'h02, 0, 2, 0, 32'h0,        1, 32'h0,         1, 0, 0, 32'h0);
    tbl[9]  = mk(32'h03, 0, 1, 0, 32'h0,        1, 32'h0,         1, 0, 0, 32'h0);
    tbl[10] = mk(32'h00, 0, 3, 0, 32'h0,        1, 32'h0,         1, 0, 0, 32'h0);
    tbl[11] = mk(32'h20, 0, 2, 0, 32'h0,        1, 32'h0,         1, 0, 0, 32'h0);
    tbl[12] = mk(32'h0E, 1, 1, 0, 32'h8001,     0, 32'h0,         3, 1, 1, 32'h80010003);
    tbl[13] = mk(32'h0E, 0, 1, 1, 32'h0,        0, 32'hFFFF_8001, 2, 1, 0, 32'h0);
    tbl[14] = mk(32'h0F, 0, 0, 1, 32'h0,        0, 32'hFFFF_FF80, 2, 1, 0, 32'h0);
    tbl[15] = mk(32'h0F, 0, 0, 0, 32'h0,        0, 32'h0000_0080, 2, 1, 0, 32'h0);
    tbl[16] = mk(32'h1F, 1, 0, 0, 32'h1FF,      0, 32'h0,         3, 1, 1, 32'hFF000007);
    tbl[17] = mk(32'h1C, 0, 2, 0, 32'h0,        0, 32'hFF00_0007, 2, 1, 0, 32'h0);
    tbl[18] = mk(32'h0C, 0, 2, 1, 32'h0,        0, 32'h8001_0003, 2, 1, 0, 32'h0);
    tbl[19] = mk(32'h08, 1, 3, 0, 32'hFFFF,     1, 32'h0,         1, 0, 0, 32'h0);
    tbl[20] = mk(32'h11, 1, 1, 0, 32'h5555,     1, 32'h0,         1, 0, 0, 32'h0);
    for (int i = 0; i < 21; i++) begin
      v = tbl[i];
      model(v);  // keeps refMem in step with the directed stores
      doReq(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset while a halfword store sits in READ: no write, no response
    while (!reqReady) @(negedge clk);
    reqAddr = 32'h0; reqWrite = 1'b1; reqSize = 2'd1; reqSigned = 1'b0; reqWData = 32'hBEEF;
    reqValid = 1'b1;
    @(negedge clk);
    reqValid = 1'b0;
    chk("rstREAD memRead in READ", {31'b0, memRead}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rstREAD memRead after reset", {31'b0, memRead}, 32'd0);
    chk("rstREAD reqReady in reset", {31'b0, reqReady}, 32'd0);
    reset = 1'b0;
    quiet = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (memWrite || respValid) quiet++;
    end
    chk("rstREAD stray write/resp cycles", 32'(quiet), 32'd0);
    chk("rstREAD reqReady after", {31'b0, reqReady}, 32'd1);
    chk("rstREAD word0 unchanged", mem[0], refMem[0]);

    // reqValid held high across three loads
    idx = 0; nResp = 0; chg = 1'b0;
    reqWrite = 1'b0; reqSize = 2'd2; reqSigned = 1'b0; reqAddr = 32'h0;
    for (int i = 0; i < 3; i++) begin acc[i] = 0; got[i] = '0; end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 0) reqValid = 1'b1;
      if (chg) begin
        chg = 1'b0;
        if (idx < 3) reqAddr = 32'(idx * 8); else reqValid = 1'b0;
      end
      if (respValid) begin
        if (nResp < 3) got[nResp] = respRData;
        nResp++;
      end
      if (reqValid && reqReady && idx < 3) begin acc[idx] = c; idx++; chg = 1'b1; end
    end
    reqValid = 1'b0;
    chk("stream accepts", 32'(idx), 32'd3);
    chk("stream responses", 32'(nResp), 32'd3);
    chk("stream spacing 0-1", 32'(acc[1] - acc[0]), 32'd3);
    chk("stream spacing 1-2", 32'(acc[2] - acc[1]), 32'd3);
    for (int i = 0; i < 3; i++) chk($sformatf("stream data%0d", i), got[i], refMem[2 * i]);

    // Random traffic against the model
    for (int i = 0; i < 60; i++) begin
      v = mk('0, 0, 0, 0, '0, 0, '0, 0, 0, 0, '0);
      v.addr = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 35));
      v.wr = 1'($urandom_range(0, 1));
      v.sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if (v.sz == 2'd2 && $urandom_range(0, 3) != 0) v.addr = v.addr & ~32'h3;
      if (v.sz == 2'd1 && $urandom_range(0, 3) != 0) v.addr = v.addr & ~32'h1;
      v.sg = 1'($urandom_range(0, 1));
      v.wd = $urandom;
      model(v);
      doReq(v, $sformatf("rnd%0d", i));
    end

    for (int i = 0; i < MW; i++) chk($sformatf("final mem[%0d]", i), mem[i], refMem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
